casez_rule_dispatch: RTL and testbench

//  Parametrised successor to the fixed casez opcode decoder: a programmable

---
 rtl/casez_rule_dispatch.sv | 218 +++++++++++++++++++++
 tb/tb_casez_rule_dispatch.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/casez_rule_dispatch.sv
// casez_rule_dispatch
//   Programmable priority-match opcode dispatcher. Each accepted opcode is
//   compared against NUM_RULES mask/value rules. The lowest-index enabled hit
//   picks one of NUM_CH operand channels. The result is presented through a
//   single registered valid/ready output stage.
//
//   Optional feature macro: CASEZ_DISPATCH_STATS_EN
//     defined   -> miss_count output: a saturating count of accepted misses
//     undefined -> no miss_count port and no counter; decode timing is unchanged
module casez_rule_dispatch #(
    parameter  int OP_W      = 4,
    parameter  int DATA_W    = 2,
    parameter  int NUM_CH    = 3,
    parameter  int NUM_RULES = 4,
    localparam int IDX_W     = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
`ifdef CASEZ_DISPATCH_STATS_EN
    output logic [15:0]              miss_count,
`endif
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          in_opcode,
    input  logic [NUM_CH*DATA_W-1:0] in_data,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [IDX_W-1:0]         out_rule,
    output logic                     out_miss,

    input  logic                     cfg_we,
    input  logic [IDX_W-1:0]         cfg_idx,
    input  logic                     cfg_en,
    input  logic [OP_W-1:0]          cfg_mask,
    input  logic [OP_W-1:0]          cfg_value,
    input  logic [CH_W-1:0]          cfg_chan
);

    // Handshake contract (both sides):
    //   A transfer happens on a rising edge where valid && ready are both high.
    //   A producer holding valid must keep its payload stable until the
    //   transfer. in_ready = !out_valid || out_ready, so one result slot is
    //   either empty or being drained this cycle; this gives 1 result per cycle
    //   with no skid buffer. While out_valid && !out_ready every out_* holds.

    // ------------------------------------------------------------------
    // Rule table
    // ------------------------------------------------------------------
    logic              en_q    [NUM_RULES];
    logic [OP_W-1:0]   mask_q  [NUM_RULES];
    logic [OP_W-1:0]   value_q [NUM_RULES];
    logic [CH_W-1:0]   chan_q  [NUM_RULES];

    logic              en_d    [NUM_RULES];
    logic [OP_W-1:0]   mask_d  [NUM_RULES];
    logic [OP_W-1:0]   value_d [NUM_RULES];
    logic [CH_W-1:0]   chan_d  [NUM_RULES];

    // Table next state: a write lands only on an index that exists, so an
    // out-of-range cfg_idx matches no entry and is silently dropped.
    always_comb begin
        for (int i = 0; i < NUM_RULES; i++) begin
            en_d[i]    = en_q[i];
            mask_d[i]  = mask_q[i];
            value_d[i] = value_q[i];
            chan_d[i]  = chan_q[i];
            if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                en_d[i]    = cfg_en;
                mask_d[i]  = cfg_mask;
                value_d[i] = cfg_value;
                chan_d[i]  = cfg_chan;
            end
        end
    end

    // Table registers; reset leaves every rule disabled with zeroed fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_RULES; i++) begin
                en_q[i]    <= 1'b0;
                mask_q[i]  <= '0;
                value_q[i] <= '0;
                chan_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RULES; i++) begin
                en_q[i]    <= en_d[i];
                mask_q[i]  <= mask_d[i];
                value_q[i] <= value_d[i];
                chan_q[i]  <= chan_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode (always against the registered table, so a same-cycle
    // configuration write only affects later opcodes)
    // ------------------------------------------------------------------
    logic [NUM_RULES-1:0] hit_vec;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [CH_W-1:0]      win_chan;
    logic [DATA_W-1:0]    sel_data;

    // Per-rule match: masked-off bits are don't-care, like ? in a casez item.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_RULES; i++) begin
            hit_vec[i] = en_q[i] && (((in_opcode ^ value_q[i]) & mask_q[i]) == '0);
        end
    end

    // Priority pick: scan from the top so the lowest hitting index is the
    // last to overwrite, which makes rule 0 the strongest.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_chan  = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_chan  = chan_q[i];
            end
        end
    end

    // Operand select; a channel number with no matching lane yields zero,
    // and so does a miss.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (win_found && (win_chan == CH_W'(k))) begin
                sel_data = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered output stage
    // ------------------------------------------------------------------
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [IDX_W-1:0]  rule_q,  rule_d;
    logic              miss_q,  miss_d;
    logic              accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Output next state: load on accept (this also covers accept-while-
    // draining), otherwise drop valid once the consumer has taken the result.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        rule_d  = rule_q;
        miss_d  = miss_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = sel_data;
            rule_d  = win_idx;
            miss_d  = !win_found;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output registers; reset discards any result still waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            rule_q  <= '0;
            miss_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            rule_q  <= rule_d;
            miss_q  <= miss_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_rule  = rule_q;
    assign out_miss  = miss_q;

`ifdef CASEZ_DISPATCH_STATS_EN
    // ------------------------------------------------------------------
    // Miss statistics
    // ------------------------------------------------------------------
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // Count accepted opcodes that hit nothing; stick at all-ones.
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (accept && !win_found && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_casez_rule_dispatch.sv
// Bench for casez_rule_dispatch: directed table/handshake scenarios followed
// by randomized traffic, all checked against a rule-table reference model and
// an expected-result queue.
module tb_casez_rule_dispatch;

    localparam int OP_W      = 4;
    localparam int DATA_W    = 2;
    localparam int NUM_CH    = 3;
    localparam int NUM_RULES = 4;
    localparam int IDX_W     = 2;
    localparam int CH_W      = 2;
    localparam int RES_W     = 1 + IDX_W + DATA_W;   // {miss, rule, data}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic                     in_valid;
    logic                     in_ready;
    logic [OP_W-1:0]          in_opcode;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [IDX_W-1:0]         out_rule;
    logic                     out_miss;
    logic                     cfg_we;
    logic [IDX_W-1:0]         cfg_idx;
    logic                     cfg_en;
    logic [OP_W-1:0]          cfg_mask;
    logic [OP_W-1:0]          cfg_value;
    logic [CH_W-1:0]          cfg_chan;
`ifdef CASEZ_DISPATCH_STATS_EN
    logic [15:0]              miss_count;
`endif

    casez_rule_dispatch #(
        .OP_W      (OP_W),
        .DATA_W    (DATA_W),
        .NUM_CH    (NUM_CH),
        .NUM_RULES (NUM_RULES)
    ) dut (
`ifdef CASEZ_DISPATCH_STATS_EN
        .miss_count (miss_count),
`endif
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rule   (out_rule),
        .out_miss   (out_miss),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_en     (cfg_en),
        .cfg_mask   (cfg_mask),
        .cfg_value  (cfg_value),
        .cfg_chan   (cfg_chan)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [RES_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic            m_en   [NUM_RULES];
    logic [OP_W-1:0] m_mask [NUM_RULES];
    logic [OP_W-1:0] m_val  [NUM_RULES];
    logic [CH_W-1:0] m_chan [NUM_RULES];
    int              m_miss_cnt;

    task automatic model_clear();
        for (int i = 0; i < NUM_RULES; i++) begin
            m_en[i]   = 1'b0;
            m_mask[i] = '0;
            m_val[i]  = '0;
            m_chan[i] = '0;
        end
        m_miss_cnt = 0;
        exp_q.delete();
    endtask

    // First enabled rule whose compared bits equal the opcode wins.
    function automatic logic [RES_W-1:0] ref_decode(input logic [OP_W-1:0] op,
                                                    input logic [NUM_CH*DATA_W-1:0] d);
        logic [RES_W-1:0]  r;
        logic [DATA_W-1:0] v;
        int                ch;
        r = {1'b1, {IDX_W{1'b0}}, {DATA_W{1'b0}}};
        for (int i = 0; i < NUM_RULES; i++) begin
            if (r[RES_W-1] && m_en[i] && (((op ^ m_val[i]) & m_mask[i]) == '0)) begin
                ch = int'(m_chan[i]);
                v  = (ch < NUM_CH) ? DATA_W'(d >> (DATA_W * ch)) : '0;
                r  = {1'b0, IDX_W'(i), v};
            end
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check_out(input string t);
        logic [RES_W-1:0] e;
        check({t, ":out_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            check({t, ":out_miss"}, 32'(out_miss), 32'(e[RES_W-1]));
            check({t, ":out_rule"}, 32'(out_rule), 32'(e[DATA_W +: IDX_W]));
            check({t, ":out_data"}, 32'(out_data), 32'(e[DATA_W-1:0]));
        end
`ifdef CASEZ_DISPATCH_STATS_EN
        check({t, ":miss_count"}, 32'(miss_count), 32'(m_miss_cnt));
`endif
    endtask

    // One clock cycle: drive at negedge, advance the model, check after the edge.
    task automatic step(input string t, input logic v, input logic [OP_W-1:0] op,
                        input logic ordy, input logic we, input logic [IDX_W-1:0] idx,
                        input logic en, input logic [OP_W-1:0] mk,
                        input logic [OP_W-1:0] vl, input logic [CH_W-1:0] ch);
        logic             exp_ready;
        logic             acc;
        logic [RES_W-1:0] r;
        in_valid  = v;
        in_opcode = op;
        out_ready = ordy;
        cfg_we    = we;
        cfg_idx   = idx;
        cfg_en    = en;
        cfg_mask  = mk;
        cfg_value = vl;
        cfg_chan  = ch;
        #1;
        exp_ready = (exp_q.size() == 0) || ordy;
        check({t, ":in_ready"}, 32'(in_ready), 32'(exp_ready));
        acc = v && exp_ready;
        r   = ref_decode(op, in_data);
        if ((exp_q.size() != 0) && ordy) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back(r);
            if (r[RES_W-1] && (m_miss_cnt < 16'hFFFF)) m_miss_cnt++;
        end
        if (we && (int'(idx) < NUM_RULES)) begin
            m_en[idx]   = en;
            m_mask[idx] = mk;
            m_val[idx]  = vl;
            m_chan[idx] = ch;
        end
        @(posedge clk);
        @(negedge clk);
        check_out(t);
    endtask

    task automatic cfg(input string t, input logic [IDX_W-1:0] idx, input logic en,
                       input logic [OP_W-1:0] mk, input logic [OP_W-1:0] vl,
                       input logic [CH_W-1:0] ch);
        step(t, 1'b0, '0, 1'b1, 1'b1, idx, en, mk, vl, ch);
    endtask

    task automatic op_in(input string t, input logic [OP_W-1:0] op, input logic ordy);
        step(t, 1'b1, op, ordy, 1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic idle(input string t, input logic ordy);
        step(t, 1'b0, '0, ordy, 1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic check_reset_outputs(input string t);
        check({t, ":out_valid"}, 32'(out_valid), 32'd0);
        check({t, ":out_data"},  32'(out_data),  32'd0);
        check({t, ":out_rule"},  32'(out_rule),  32'd0);
        check({t, ":out_miss"},  32'(out_miss),  32'd0);
        check({t, ":in_ready"},  32'(in_ready),  32'd1);
`ifdef CASEZ_DISPATCH_STATS_EN
        check({t, ":miss_count"}, 32'(miss_count), 32'd0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_data   = 6'b11_10_01;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_en    = 1'b0;
        cfg_mask  = '0;
        cfg_value = '0;
        cfg_chan  = '0;
        model_clear();

        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_rel");

        // Table setup
        cfg("cfg0", 2'd0, 1'b1, 4'b1000, 4'b1000, 2'd0);
        cfg("cfg1", 2'd1, 1'b1, 4'b1100, 4'b0100, 2'd1);
        cfg("cfg2", 2'd2, 1'b1, 4'b1110, 4'b0010, 2'd2);

        // T1: single opcode, 1-cycle latency
        op_in("t1", 4'b1011, 1'b1);
        check("t1:rule_const", 32'(out_rule), 32'd0);
        check("t1:data_const", 32'(out_data), 32'b01);

        // T2: back-to-back at full rate
        op_in("t2a", 4'b0101, 1'b1);
        op_in("t2b", 4'b0010, 1'b1);
        op_in("t2c", 4'b0000, 1'b1);
        check("t2c:miss_const", 32'(out_miss), 32'd1);
        check("t2c:data_const", 32'(out_data), 32'd0);
        idle("t2_drain", 1'b1);

        // T3: backpressure holds the result
        op_in("t3a", 4'b0101, 1'b0);
        op_in("t3_hold1", 4'b0010, 1'b0);
        op_in("t3_hold2", 4'b0010, 1'b0);
        op_in("t3b", 4'b0010, 1'b1);
        check("t3b:rule_const", 32'(out_rule), 32'd2);
        idle("t3_drain", 1'b1);

        // T4: catch-all rule 3 and priority
        cfg("cfg3", 2'd3, 1'b1, 4'b0000, 4'b0000, 2'd2);
        op_in("t4a", 4'b0000, 1'b1);
        op_in("t4b", 4'b1011, 1'b1);

        // T5: same-cycle write uses the pre-write table
        step("t5a", 1'b1, 4'b1011, 1'b1, 1'b1, 2'd0, 1'b0, 4'b1000, 4'b1000, 2'd0);
        check("t5a:rule_const", 32'(out_rule), 32'd0);
        op_in("t5b", 4'b1011, 1'b1);
        check("t5b:rule_const", 32'(out_rule), 32'd3);
        idle("t5_drain", 1'b1);

        // Unmapped channel on a hit gives zero data without a miss
        cfg("cfg_ch3", 2'd1, 1'b1, 4'b1111, 4'b0110, 2'd3);
        op_in("chan3", 4'b0110, 1'b1);
        idle("chan3_drain", 1'b1);

        // T6: reset while a result is stalled
        op_in("t6a", 4'b0101, 1'b0);
        idle("t6_hold", 1'b0);
        reset = 1'b1;
        #1;
        model_clear();
        check_reset_outputs("t6_rst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("t6_rel");
        idle("t6_quiet", 1'b0);
        op_in("t6b", 4'b0101, 1'b1);
        check("t6b:miss_const", 32'(out_miss), 32'd1);
        idle("t6_drain", 1'b1);

        // Randomized traffic with live reconfiguration and backpressure
        for (int n = 0; n < 400; n++) begin
            in_data = (NUM_CH*DATA_W)'($urandom);
            step("rnd",
                 $urandom_range(0, 3) != 0,
                 OP_W'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0,
                 IDX_W'($urandom_range(0, NUM_RULES - 1)),
                 $urandom_range(0, 3) != 0,
                 OP_W'($urandom_range(0, 15)),
                 OP_W'($urandom_range(0, 15)),
                 CH_W'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
